// File: rtl/ece423_pio_ctl.sv
// ============================================================================
// ece423_pio_ctl : Avalon-MM PIO with set/clear output, synchronised input,
//                  per-bit edge capture and maskable level irq.
// Optional: define ECE423_PIO_TOGGLE_EN to turn address 6 into OUTTOGGLE.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ece423_pio_ctl #(
   parameter int          WIDTH          = 8,
   parameter logic [31:0] RESET_VALUE    = 32'h0,
   parameter int          EDGE_TYPE      = 0,
   parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_INPUT    = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
`ifdef ECE423_PIO_TOGGLE_EN
   localparam logic [2:0] ADDR_TOGGLE   = 3'd6;
`endif
   localparam logic [1:0] ARM_DONE      = 2'd3;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_nxt;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] in_s1;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_prev;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] rd_narrow;
   logic [1:0]       arm_cnt;

   assign wr = chipselect & ~write_n;
   assign wd = writedata[WIDTH-1:0];

   generate
      if (WIDTH < 32) begin : g_unused_wd
         logic unused_wd_hi;
         assign unused_wd_hi = ^writedata[31:WIDTH];
      end
   endgenerate

   // Output register next value; only one address can be written per cycle.
   always_comb begin
      data_nxt = data_out;
      if (wr) begin
         case (address)
            ADDR_DATA:     data_nxt = wd;
            ADDR_OUTSET:   data_nxt = data_out | wd;
            ADDR_OUTCLEAR: data_nxt = data_out & ~wd;
`ifdef ECE423_PIO_TOGGLE_EN
            ADDR_TOGGLE:   data_nxt = data_out ^ wd;
`endif
            default:       data_nxt = data_out;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= RESET_VALUE[WIDTH-1:0];
         irq_mask <= IRQ_MASK_RESET[WIDTH-1:0];
      end else begin
         data_out <= data_nxt;
         if (wr && (address == ADDR_IRQ_MASK)) begin
            irq_mask <= wd;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_s1   <= '0;
         in_sync <= '0;
         in_prev <= '0;
         arm_cnt <= 2'd0;
      end else begin
         in_s1   <= in_port;
         in_sync <= in_s1;
         in_prev <= in_sync;
         if (arm_cnt != ARM_DONE) begin
            arm_cnt <= arm_cnt + 2'd1;
         end
      end
   end

   generate
      if (EDGE_TYPE == 1) begin : g_edge_fall
         assign edge_raw = ~in_sync & in_prev;
      end else if (EDGE_TYPE == 2) begin : g_edge_any
         assign edge_raw = in_sync ^ in_prev;
      end else begin : g_edge_rise
         assign edge_raw = in_sync & ~in_prev;
      end
   endgenerate

   // Suppress edges until the synchroniser holds real samples, so pins that
   // are already high when reset releases do not register as edges.
   assign edge_det = (arm_cnt == ARM_DONE) ? edge_raw : '0;
   assign clr_mask = (wr && (address == ADDR_EDGE_CAP)) ? wd : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_cap <= '0;
      end else begin
         edge_cap <= edge_det | (edge_cap & ~clr_mask);
      end
   end

   assign irq      = |(edge_cap & irq_mask);
   assign out_port = data_out;

   always_comb begin
      rd_narrow = '0;
      case (address)
         ADDR_DATA:     rd_narrow = data_out;
         ADDR_INPUT:    rd_narrow = in_sync;
         ADDR_IRQ_MASK: rd_narrow = irq_mask;
         ADDR_EDGE_CAP: rd_narrow = edge_cap;
         default:       rd_narrow = '0;
      endcase
   end

   assign readdata = 32'(rd_narrow);

endmodule

`default_nettype wire

// File: tb/tb_ece423_pio_ctl.sv
// ============================================================================
// tb_ece423_pio_ctl : self-checking bench for ece423_pio_ctl (WIDTH=8,
//                     RESET_VALUE=8'hA5, rising-edge capture).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ece423_pio_ctl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic [7:0]  in_port = 8'h00;
   logic [7:0]  out_port;
   logic        irq;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ece423_pio_ctl #(
      .WIDTH(8),
      .RESET_VALUE(32'hA5),
      .EDGE_TYPE(0),
      .IRQ_MASK_RESET(32'h0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .out_port(out_port),
      .irq(irq)
   );

   // Reference model: pin samples since reset are kept in a short history;
   // an edge is only recognised once four samples exist.
   logic [7:0] m_out, m_mask, m_cap;
   logic [7:0] m_wd, m_det, m_clr;
   logic [7:0] hist[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_out  = 8'hA5;
         m_mask = 8'h00;
         m_cap  = 8'h00;
         hist.delete();
      end else begin
         m_wd  = writedata[7:0];
         m_clr = 8'h00;
         m_det = 8'h00;
         hist.push_front(in_port);
         if (hist.size() > 4) void'(hist.pop_back());
         if (hist.size() == 4) m_det = hist[2] & ~hist[3];
         if (chipselect && !write_n) begin
            case (address)
               3'd0: m_out = m_wd;
               3'd2: m_mask = m_wd;
               3'd3: m_clr = m_wd;
               3'd4: m_out = m_out | m_wd;
               3'd5: m_out = m_out & ~m_wd;
`ifdef ECE423_PIO_TOGGLE_EN
               3'd6: m_out = m_out ^ m_wd;
`endif
               default: ;
            endcase
         end
         m_cap = m_det | (m_cap & ~m_clr);
      end
   end

   function automatic logic [31:0] exp_rd(input logic [2:0] a);
      case (a)
         3'd0: return {24'h0, m_out};
         3'd1: return (hist.size() > 1) ? {24'h0, hist[1]} : 32'h0;
         3'd2: return {24'h0, m_mask};
         3'd3: return {24'h0, m_cap};
         default: return 32'h0;
      endcase
   endfunction

   // Called at a negedge; applies one bus cycle and returns at the next negedge.
   task automatic tick(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] d);
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = d;
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic test_reset();
      in_port = 8'hFF;
      @(negedge clk);
      address = 3'd0;
      #1;
      checks++;
      if (out_port !== 8'hA5) begin
         failures++;
         $display("FAIL reset_out actual=%h expected=a5", out_port);
      end
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_irq actual=%b expected=0", irq);
      end
      checks++;
      if (readdata !== 32'h0000_00A5) begin
         failures++;
         $display("FAIL reset_rd0 actual=%h expected=000000a5", readdata);
      end
      reset = 1'b0;
      tick(1'b1, 1'b0, 3'd0, 32'h5A);
      checks++;
      if (out_port !== 8'h5A) begin
         failures++;
         $display("FAIL pre_reset_write actual=%h expected=5a", out_port);
      end
      chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h77;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_port !== 8'hA5) begin
         failures++;
         $display("FAIL async_reset_out actual=%h expected=a5", out_port);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_port !== 8'hA5) begin
         failures++;
         $display("FAIL reset_discards_write actual=%h expected=a5", out_port);
      end
      chipselect = 1'b0; write_n = 1'b1;
      reset = 1'b0;
   endtask

   task automatic test_arming();
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b1, 3'd3, 32'h0);
         #1;
         checks++;
         if (readdata !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL arm_no_capture cyc=%0d actual=%h expected=00000000", i, readdata);
         end
      end
      in_port = 8'hFB;
      repeat (4) tick(1'b0, 1'b1, 3'd3, 32'h0);
      in_port = 8'hFF;
      tick(1'b0, 1'b1, 3'd1, 32'h0);
      #1;
      checks++;
      if (readdata !== 32'h0000_00FB) begin
         failures++;
         $display("FAIL sync_1clk actual=%h expected=000000fb", readdata);
      end
      tick(1'b0, 1'b1, 3'd1, 32'h0);
      #1;
      checks++;
      if (readdata !== 32'h0000_00FF) begin
         failures++;
         $display("FAIL sync_2clk actual=%h expected=000000ff", readdata);
      end
      address = 3'd3;
      #1;
      checks++;
      if (readdata !== 32'h0) begin
         failures++;
         $display("FAIL cap_2clk actual=%h expected=00000000", readdata);
      end
      tick(1'b0, 1'b1, 3'd3, 32'h0);
      #1;
      checks++;
      if (readdata !== 32'h0000_0004 || readdata !== exp_rd(3'd3)) begin
         failures++;
         $display("FAIL cap_3clk actual=%h expected=00000004", readdata);
      end
   endtask

   task automatic test_data_regs();
      logic [7:0]  exp_out[3] = '{8'h3C, 8'h3F, 8'h33};
      logic [2:0]  addrs[3]   = '{3'd0, 3'd4, 3'd5};
      logic [31:0] datas[3]   = '{32'hFFFF_FF3C, 32'h03, 32'h0C};
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, addrs[i], datas[i]);
         address = 3'd0;
         #1;
         checks++;
         if (out_port !== exp_out[i] || readdata !== {24'h0, exp_out[i]}) begin
            failures++;
            $display("FAIL data_write step=%0d actual=%h/%h expected=%h", i, out_port, readdata, exp_out[i]);
         end
         address = addrs[i] == 3'd0 ? 3'd4 : addrs[i];
         #1;
         checks++;
         if (readdata !== 32'h0) begin
            failures++;
            $display("FAIL set_clr_read addr=%0d actual=%h expected=00000000", address, readdata);
         end
      end
   endtask

   task automatic test_irq();
      tick(1'b1, 1'b0, 3'd2, 32'h04);
      address = 3'd2;
      #1;
      checks++;
      if (irq !== 1'b1 || readdata !== 32'h4) begin
         failures++;
         $display("FAIL irq_assert actual=%b/%h expected=1/00000004", irq, readdata);
      end
      tick(1'b1, 1'b0, 3'd3, 32'h04);
      address = 3'd3;
      #1;
      checks++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
         failures++;
         $display("FAIL irq_clear actual=%b/%h expected=0/00000000", irq, readdata);
      end
   endtask

   task automatic test_edge_wins();
      in_port = 8'hFD;
      repeat (4) tick(1'b0, 1'b1, 3'd3, 32'h0);
      in_port = 8'hFF;
      repeat (4) tick(1'b0, 1'b1, 3'd3, 32'h0);
      #1;
      checks++;
      if (readdata !== 32'h2) begin
         failures++;
         $display("FAIL bit1_captured actual=%h expected=00000002", readdata);
      end
      in_port = 8'hFD;
      repeat (4) tick(1'b0, 1'b1, 3'd3, 32'h0);
      in_port = 8'hFF;
      tick(1'b0, 1'b1, 3'd3, 32'h0);
      tick(1'b0, 1'b1, 3'd3, 32'h0);
      tick(1'b1, 1'b0, 3'd3, 32'h02);
      address = 3'd3;
      #1;
      checks++;
      if (readdata !== 32'h2) begin
         failures++;
         $display("FAIL edge_wins_clear actual=%h expected=00000002", readdata);
      end
      tick(1'b1, 1'b0, 3'd3, 32'h02);
      address = 3'd3;
      #1;
      checks++;
      if (readdata !== 32'h0) begin
         failures++;
         $display("FAIL plain_clear actual=%h expected=00000000", readdata);
      end
   endtask

   task automatic test_toggle();
      logic [7:0] expv;
`ifdef ECE423_PIO_TOGGLE_EN
      expv = 8'hF0;
`else
      expv = 8'h0F;
`endif
      tick(1'b1, 1'b0, 3'd0, 32'h0F);
      tick(1'b1, 1'b0, 3'd6, 32'hFF);
      address = 3'd6;
      #1;
      checks++;
      if (out_port !== expv || readdata !== 32'h0) begin
         failures++;
         $display("FAIL toggle_addr6 actual=%h/%h expected=%h/00000000", out_port, readdata, expv);
      end
   endtask

   task automatic test_random();
      logic [2:0] ra;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1'b1;
            #1;
            checks++;
            if (out_port !== 8'hA5 || irq !== 1'b0) begin
               failures++;
               $display("FAIL rand_async_reset cyc=%0d actual=%h/%b expected=a5/0", i, out_port, irq);
            end
            #1 reset = 1'b0;
         end
         tick($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 3'($urandom),
              $urandom);
         checks++;
         if (out_port !== m_out || irq !== |(m_cap & m_mask)) begin
            failures++;
            $display("FAIL rand_state cyc=%0d actual=%h/%b expected=%h/%b", i, out_port, irq, m_out, |(m_cap & m_mask));
         end
         ra = 3'($urandom);
         address = ra;
         #1;
         checks++;
         if (readdata !== exp_rd(ra)) begin
            failures++;
            $display("FAIL rand_read cyc=%0d addr=%0d actual=%h expected=%h", i, ra, readdata, exp_rd(ra));
         end
      end
   endtask

   initial begin
      test_reset();
      test_arming();
      test_data_regs();
      test_irq();
      test_edge_wins();
      test_toggle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
